// File: rtl/mcb_pkg.sv
// Shared definitions for the MCB burst engine.
//   - MCB command instruction encodings (write, read, write/read with
//     auto-precharge, refresh).
//   - FSM state encoding used by mcb_burst_engine.
//   - MCB_MAX_BL: largest burst one MCB command can carry (bl field is 6 bits).
package mcb_pkg;

  localparam logic [2:0] MCB_CMD_WR = 3'b000;
  localparam logic [2:0] MCB_CMD_RD = 3'b001;
  localparam logic [2:0] MCB_CMD_WP = 3'b010;
  localparam logic [2:0] MCB_CMD_RP = 3'b011;
  localparam logic [2:0] MCB_CMD_RF = 3'b100;

  localparam int MCB_MAX_BL = 64;
  // Width able to hold a word count 0..MCB_MAX_BL inclusive.
  localparam int MCB_BL_W   = $clog2(MCB_MAX_BL) + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_FILL,
    ST_WR_CMD,
    ST_RD_CMD,
    ST_RD_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/mcb_burst_calc.sv
// Combinational burst splitter.
// Given the words still to be commanded and the current byte address,
// produce the next burst length (min(remaining, MAX_BURST)), the byte
// address following that burst (30-bit wrap-around, no 4K split) and the
// words left afterwards.
// Ports:
//   rem_i        words not yet covered by a command
//   addr_i       byte address of the next command
//   blen_o       words in the next command
//   next_addr_o  byte address after this command
//   next_rem_o   words remaining after this command
module mcb_burst_calc
  import mcb_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int MAX_BURST  = 64,
  parameter int LEN_W      = 16
) (
  input  logic [LEN_W-1:0]    rem_i,
  input  logic [29:0]         addr_i,
  output logic [MCB_BL_W-1:0] blen_o,
  output logic [29:0]         next_addr_o,
  output logic [LEN_W-1:0]    next_rem_o
);

  localparam int               WORD_BYTES = DATA_WIDTH / 8;
  localparam logic [LEN_W-1:0] MAXB       = MAX_BURST[LEN_W-1:0];
  localparam logic [29:0]      WB         = WORD_BYTES[29:0];

  logic [LEN_W-1:0] take;

  always_comb begin
    take        = (rem_i < MAXB) ? rem_i : MAXB;
    blen_o      = MCB_BL_W'(take);
    next_addr_o = addr_i + 30'(take) * WB;
    next_rem_o  = rem_i - take;
  end

endmodule

// File: rtl/mcb_burst_engine.sv
// User-port adapter for one Spartan-6 MCB port.
// Takes one long transfer request and splits it into MCB bursts of at most
// MAX_BURST words. Write commands are issued once the write FIFO holds the
// whole burst; read commands are issued only when the read FIFO has room
// for the whole burst (outstanding + blen <= FIFO_DEPTH).
// Optional feature macro: MCB_ERR_LATCH_EN -- when defined, err_status
// latches {rd_err, rd_ovf, wr_err, wr_unr}; when undefined it is tied to 0.
// Ports:
//   u_req/u_req_rdy/u_req_wr/u_req_addr/u_req_len   request handshake
//   u_wr_data/u_wr_en/u_wr_rdy                      write data in
//   u_rd_data/u_rd_valid/u_rd_en                    read data out
//   u_done                                          1-cycle completion pulse
//   mcb_cmd_*                                       MCB command port
//   mcb_wr_*                                        MCB write data FIFO
//   mcb_rd_*                                        MCB read data FIFO
//   err_status                                      sticky MCB error flags
module mcb_burst_engine
  import mcb_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int MAX_BURST  = 64,
  parameter int FIFO_DEPTH = 64,
  parameter int LEN_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    u_req,
  output logic                    u_req_rdy,
  input  logic                    u_req_wr,
  input  logic [29:0]             u_req_addr,
  input  logic [LEN_W-1:0]        u_req_len,
  input  logic [DATA_WIDTH-1:0]   u_wr_data,
  input  logic                    u_wr_en,
  output logic                    u_wr_rdy,
  output logic [DATA_WIDTH-1:0]   u_rd_data,
  output logic                    u_rd_valid,
  input  logic                    u_rd_en,
  output logic                    u_done,
  output logic                    mcb_cmd_en,
  output logic [2:0]              mcb_cmd_instr,
  output logic [5:0]              mcb_cmd_bl,
  output logic [29:0]             mcb_cmd_byte_addr,
  input  logic                    mcb_cmd_full,
  output logic                    mcb_wr_en,
  output logic [DATA_WIDTH/8-1:0] mcb_wr_mask,
  output logic [DATA_WIDTH-1:0]   mcb_wr_data,
  input  logic                    mcb_wr_full,
  input  logic                    mcb_wr_underrun,
  input  logic                    mcb_wr_error,
  output logic                    mcb_rd_en,
  input  logic [DATA_WIDTH-1:0]   mcb_rd_data,
  input  logic                    mcb_rd_empty,
  input  logic                    mcb_rd_overflow,
  input  logic                    mcb_rd_error,
  output logic [3:0]              err_status
);

  localparam int            OW      = LEN_W + 1;
  localparam logic [OW:0]   DEPTH_L = FIFO_DEPTH[OW:0];

  state_e                state_q, state_d;
  logic [29:0]           addr_q, addr_d;
  logic [LEN_W-1:0]      rem_q, rem_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      popped_q, popped_d;
  logic [MCB_BL_W-1:0]   cnt_q, cnt_d;
  logic [OW-1:0]         out_q, out_d;
  logic                  cmd_q, cmd_d;

  logic [MCB_BL_W-1:0]   blen;
  logic [29:0]           next_addr;
  logic [LEN_W-1:0]      next_rem;
  logic [OW:0]           need;
  logic                  rd_phase, issue, req_take;

  mcb_burst_calc #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_BURST  (MAX_BURST),
    .LEN_W      (LEN_W)
  ) u_calc (
    .rem_i       (rem_q),
    .addr_i      (addr_q),
    .blen_o      (blen),
    .next_addr_o (next_addr),
    .next_rem_o  (next_rem)
  );

  // Read FIFO occupancy if the next burst were commanded now.
  assign need = {1'b0, out_q} + {{(OW + 1 - MCB_BL_W){1'b0}}, blen};

  assign u_rd_data   = mcb_rd_data;
  assign mcb_wr_mask = '0;
  assign mcb_wr_data = mcb_wr_en ? u_wr_data : '0;

  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    rem_d             = rem_q;
    len_d             = len_q;
    popped_d          = popped_q;
    cnt_d             = cnt_q;
    out_d             = out_q;
    cmd_d             = 1'b0;
    issue             = 1'b0;
    req_take          = 1'b0;
    u_req_rdy         = 1'b0;
    u_wr_rdy          = 1'b0;
    mcb_wr_en         = 1'b0;
    mcb_cmd_en        = 1'b0;
    mcb_cmd_instr     = 3'b000;
    mcb_cmd_bl        = 6'd0;
    mcb_cmd_byte_addr = 30'd0;
    u_done            = 1'b0;

    rd_phase   = (state_q == ST_RD_CMD) || (state_q == ST_RD_DRAIN);
    u_rd_valid = rd_phase & ~mcb_rd_empty;
    mcb_rd_en  = u_rd_valid & u_rd_en;
    if (mcb_rd_en) popped_d = popped_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        u_req_rdy = 1'b1;
        // A zero-length request is dropped without leaving IDLE.
        if (u_req && (u_req_len != '0)) begin
          req_take = 1'b1;
          addr_d   = u_req_addr;
          rem_d    = u_req_len;
          len_d    = u_req_len;
          popped_d = '0;
          cnt_d    = '0;
          out_d    = '0;
          state_d  = u_req_wr ? ST_WR_FILL : ST_RD_CMD;
        end
      end
      ST_WR_FILL: begin
        u_wr_rdy  = ~mcb_wr_full;
        mcb_wr_en = u_wr_en & u_wr_rdy;
        if (mcb_wr_en) begin
          if (cnt_q + 1'b1 == blen) begin
            cnt_d   = '0;
            state_d = ST_WR_CMD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_WR_CMD: begin
        if (!mcb_cmd_full) begin
          mcb_cmd_en        = 1'b1;
          mcb_cmd_instr     = MCB_CMD_WP;
          mcb_cmd_bl        = 6'(blen - 1'b1);
          mcb_cmd_byte_addr = addr_q;
          cmd_d             = 1'b1;
          addr_d            = next_addr;
          rem_d             = next_rem;
          state_d           = (next_rem == '0) ? ST_DONE : ST_WR_FILL;
        end
      end
      ST_RD_CMD: begin
        // cmd_q forces an idle cycle between consecutive read commands.
        if (!mcb_cmd_full && !cmd_q && (need <= DEPTH_L)) begin
          issue             = 1'b1;
          mcb_cmd_en        = 1'b1;
          mcb_cmd_instr     = MCB_CMD_RP;
          mcb_cmd_bl        = 6'(blen - 1'b1);
          mcb_cmd_byte_addr = addr_q;
          cmd_d             = 1'b1;
          addr_d            = next_addr;
          rem_d             = next_rem;
          if (next_rem == '0) state_d = ST_RD_DRAIN;
        end
      end
      ST_RD_DRAIN: begin
        if (popped_q == len_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        u_done  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outstanding read words: commanded minus popped, both can happen together.
    if (rd_phase) begin
      out_d = out_q
            + (issue ? {{(OW - MCB_BL_W){1'b0}}, blen} : '0)
            - {{(OW - 1){1'b0}}, mcb_rd_en};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      len_q    <= '0;
      popped_q <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      cmd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      len_q    <= len_d;
      popped_q <= popped_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      cmd_q    <= cmd_d;
    end
  end

`ifdef MCB_ERR_LATCH_EN
  logic [3:0] err_q, err_d;

  // A new request clears history; an error in the same cycle still sticks.
  always_comb begin
    err_d = req_take ? 4'b0000 : err_q;
    err_d = err_d | {mcb_rd_error, mcb_rd_overflow, mcb_wr_error, mcb_wr_underrun};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 4'b0000;
    else        err_q <= err_d;
  end

  assign err_status = err_q;
`else
  logic unused_err;
  assign unused_err = ^{mcb_rd_error, mcb_rd_overflow, mcb_wr_error, mcb_wr_underrun, req_take};
  assign err_status = 4'b0000;
`endif

endmodule

// File: tb/tb_mcb_burst_engine.sv
`timescale 1ns/1ps
module tb_mcb_burst_engine;
  import mcb_pkg::*;

  localparam int DW = 128;
  localparam int MB = 64;
  localparam int FD = 64;
  localparam int LW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            u_req = 1'b0, u_req_rdy, u_req_wr = 1'b0;
  logic [29:0]     u_req_addr = '0;
  logic [LW-1:0]   u_req_len = '0;
  logic [DW-1:0]   u_wr_data;
  logic            u_wr_en, u_wr_rdy;
  logic [DW-1:0]   u_rd_data;
  logic            u_rd_valid, u_rd_en = 1'b0, u_done;
  logic            mcb_cmd_en;
  logic [2:0]      mcb_cmd_instr;
  logic [5:0]      mcb_cmd_bl;
  logic [29:0]     mcb_cmd_byte_addr;
  logic            mcb_cmd_full = 1'b0;
  logic            mcb_wr_en;
  logic [DW/8-1:0] mcb_wr_mask;
  logic [DW-1:0]   mcb_wr_data;
  logic            mcb_wr_full = 1'b0, mcb_wr_underrun = 1'b0, mcb_wr_error = 1'b0;
  logic            mcb_rd_en;
  logic [DW-1:0]   mcb_rd_data;
  logic            mcb_rd_empty;
  logic            mcb_rd_overflow = 1'b0, mcb_rd_error = 1'b0;
  logic [3:0]      err_status;

  always #5 clk = ~clk;

  mcb_burst_engine #(.DATA_WIDTH(DW), .MAX_BURST(MB), .FIFO_DEPTH(FD), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .u_req(u_req), .u_req_rdy(u_req_rdy), .u_req_wr(u_req_wr),
    .u_req_addr(u_req_addr), .u_req_len(u_req_len),
    .u_wr_data(u_wr_data), .u_wr_en(u_wr_en), .u_wr_rdy(u_wr_rdy),
    .u_rd_data(u_rd_data), .u_rd_valid(u_rd_valid), .u_rd_en(u_rd_en),
    .u_done(u_done),
    .mcb_cmd_en(mcb_cmd_en), .mcb_cmd_instr(mcb_cmd_instr), .mcb_cmd_bl(mcb_cmd_bl),
    .mcb_cmd_byte_addr(mcb_cmd_byte_addr), .mcb_cmd_full(mcb_cmd_full),
    .mcb_wr_en(mcb_wr_en), .mcb_wr_mask(mcb_wr_mask), .mcb_wr_data(mcb_wr_data),
    .mcb_wr_full(mcb_wr_full), .mcb_wr_underrun(mcb_wr_underrun), .mcb_wr_error(mcb_wr_error),
    .mcb_rd_en(mcb_rd_en), .mcb_rd_data(mcb_rd_data), .mcb_rd_empty(mcb_rd_empty),
    .mcb_rd_overflow(mcb_rd_overflow), .mcb_rd_error(mcb_rd_error),
    .err_status(err_status)
  );

  int vecs = 0;
  int errs = 0;

  // Model state: expected command stream, write data, read data sequence.
  logic [38:0]   exp_cmd[$];
  logic [38:0]   cap[$];
  logic [DW-1:0] exp_wr[$];
  logic [DW-1:0] rd_fifo[$];
  int            rd_pend = 0;
  int            rd_remaining = 0;
  logic [DW-1:0] rd_seq = '0;
  logic [DW-1:0] exp_rd_next = '0;
  logic [DW-1:0] wr_word = 128'h1000;
  int            wr_todo = 0;
  int            dones = 0;
  logic          mdl_rp, mdl_pop;
  int            mdl_nbl;
  logic          prev_cmd = 1'b0, prev_done = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic bad(input string name, input logic [127:0] act);
    vecs++;
    errs++;
    $display("FAIL %s: got 0x%0h expected nothing", name, act);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural MCB: a read command delivers its words one per cycle into
  // the read FIFO; the FIFO must never exceed its depth.
  initial begin
    mcb_rd_empty = 1'b1;
    mcb_rd_data  = '0;
    forever begin
      @(negedge clk);
      mdl_rp  = mcb_cmd_en && (mcb_cmd_instr == MCB_CMD_RP);
      mdl_nbl = int'(mcb_cmd_bl) + 1;
      mdl_pop = mcb_rd_en;
      @(posedge clk);
      #1;
      if (mdl_pop && rd_fifo.size() > 0) void'(rd_fifo.pop_front());
      if (rd_pend > 0) begin
        rd_fifo.push_back(rd_seq);
        rd_seq++;
        rd_pend--;
        chk("rd_fifo_no_overflow", 128'(rd_fifo.size() <= FD), 128'd1);
      end
      if (mdl_rp) rd_pend += mdl_nbl;
      mcb_rd_empty = (rd_fifo.size() == 0);
      mcb_rd_data  = (rd_fifo.size() > 0) ? rd_fifo[0] : '0;
    end
  end

  // Write data source: offers sequential words while wr_todo > 0.
  initial begin
    u_wr_en   = 1'b0;
    u_wr_data = '0;
    forever begin
      @(posedge clk);
      #1;
      u_wr_en   = (wr_todo > 0);
      u_wr_data = wr_word;
      @(negedge clk);
      if (u_wr_en && u_wr_rdy) begin
        wr_word++;
        wr_todo--;
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mcb_cmd_en) begin
          chk("cmd_not_back_to_back", 128'(prev_cmd), 128'd0);
          if (exp_cmd.size() == 0) bad("cmd_unexpected", {mcb_cmd_instr, mcb_cmd_bl, mcb_cmd_byte_addr});
          else chk("cmd", {mcb_cmd_instr, mcb_cmd_bl, mcb_cmd_byte_addr}, exp_cmd.pop_front());
          cap.push_back({mcb_cmd_instr, mcb_cmd_bl, mcb_cmd_byte_addr});
        end
        prev_cmd = mcb_cmd_en;
        if (mcb_wr_en) begin
          chk("wr_mask", 128'(mcb_wr_mask), 128'd0);
          if (exp_wr.size() == 0) bad("wr_unexpected", mcb_wr_data);
          else chk("wr_data", mcb_wr_data, exp_wr.pop_front());
        end
        if (mcb_rd_en) begin
          chk("rd_data", u_rd_data, exp_rd_next);
          exp_rd_next++;
          rd_remaining--;
        end
        if (u_done) begin
          chk("done_single_cycle", 128'(prev_done), 128'd0);
          chk("done_cmds_left", 128'(exp_cmd.size()), 128'd0);
          chk("done_rd_left", 128'(rd_remaining), 128'd0);
          chk("done_wr_left", 128'(exp_wr.size()), 128'd0);
          dones++;
        end
        prev_done = u_done;
      end
    end
  end

  task automatic request(input logic wr, input logic [29:0] addr, input int len);
    int rem;
    int b;
    logic [29:0] a;
    rem = len;
    a   = addr;
    while (rem > 0) begin
      b = (rem < MB) ? rem : MB;
      exp_cmd.push_back({(wr ? MCB_CMD_WP : MCB_CMD_RP), 6'(b - 1), a});
      a   = a + 30'(b * DW / 8);
      rem = rem - b;
    end
    if (wr) begin
      for (int i = 0; i < len; i++) exp_wr.push_back(wr_word + DW'(i));
      wr_todo = len;
    end else begin
      rd_remaining = len;
    end
    u_req      = 1'b1;
    u_req_wr   = wr;
    u_req_addr = addr;
    u_req_len  = LW'(len);
    tick();
    u_req = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    for (n = 0; n < budget; n++) begin
      @(negedge clk);
      if (u_done) break;
    end
    chk({name, "_done_in_time"}, 128'(n < budget), 128'd1);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int d0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_req_rdy", 128'(u_req_rdy), 128'd1);
    chk("rst_done", 128'(u_done), 128'd0);
    chk("rst_cmd_en", 128'(mcb_cmd_en), 128'd0);
    chk("rst_wr_en", 128'(mcb_wr_en), 128'd0);
    chk("rst_wr_rdy", 128'(u_wr_rdy), 128'd0);
    chk("rst_rd_valid", 128'(u_rd_valid), 128'd0);
    chk("rst_rd_en", 128'(mcb_rd_en), 128'd0);
    chk("rst_err", 128'(err_status), 128'd0);
    tick();

    // Single-word write at 0x100
    request(1'b1, 30'h100, 1);
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (mcb_cmd_en) break;
    end
    chk("w1_cmd_seen", 128'(n < 40), 128'd1);
    chk("w1_instr", 128'(mcb_cmd_instr), 128'h2);
    chk("w1_bl", 128'(mcb_cmd_bl), 128'h0);
    chk("w1_addr", 128'(mcb_cmd_byte_addr), 128'h100);
    @(negedge clk);
    chk("w1_done_next", 128'(u_done), 128'd1);
    tick();

    // 150-word write at 0 with a write-FIFO-full hiccup
    cap.delete();
    request(1'b1, 30'h0, 150);
    repeat (20) tick();
    mcb_wr_full = 1'b1;
    repeat (3) tick();
    mcb_wr_full = 1'b0;
    wait_done("w150", 600);
    chk("w150_ncmd", 128'(cap.size()), 128'd3);
    if (cap.size() == 3) begin
      chk("w150_cmd0", 128'(cap[0]), {89'd0, 3'b010, 6'd63, 30'h000});
      chk("w150_cmd1", 128'(cap[1]), {89'd0, 3'b010, 6'd63, 30'h400});
      chk("w150_cmd2", 128'(cap[2]), {89'd0, 3'b010, 6'd21, 30'h800});
    end

    // Command FIFO full for 5 cycles while a write command is pending
    mcb_cmd_full = 1'b1;
    request(1'b1, 30'h2000, 4);
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (wr_todo == 0) break;
    end
    chk("cf_data_pushed", 128'(n < 40), 128'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("cf_cmd_held", 128'(mcb_cmd_en), 128'd0);
    end
    tick();
    mcb_cmd_full = 1'b0;
    @(negedge clk);
    chk("cf_cmd_release", 128'(mcb_cmd_en), 128'd1);
    @(negedge clk);
    chk("cf_cmd_single", 128'(mcb_cmd_en), 128'd0);
    chk("cf_done", 128'(u_done), 128'd1);
    tick();

    // 130-word read with a stalled consumer
    cap.delete();
    u_rd_en = 1'b0;
    request(1'b0, 30'h10000, 130);
    repeat (100) @(negedge clk);
    chk("rd_stall_ncmd", 128'(cap.size()), 128'd1);
    chk("rd_stall_valid", 128'(u_rd_valid), 128'd1);
    chk("rd_busy_rdy", 128'(u_req_rdy), 128'd0);
    tick();
    u_req = 1'b1; u_req_wr = 1'b1; u_req_addr = 30'h5000; u_req_len = 16'd5;
    tick();
    u_req = 1'b0;
    u_rd_en = 1'b1;
    wait_done("rd130", 1000);
    chk("rd130_ncmd", 128'(cap.size()), 128'd3);
    if (cap.size() == 3) begin
      chk("rd130_cmd0", 128'(cap[0]), {89'd0, 3'b011, 6'd63, 30'h10000});
      chk("rd130_cmd1", 128'(cap[1]), {89'd0, 3'b011, 6'd63, 30'h10400});
      chk("rd130_cmd2", 128'(cap[2]), {89'd0, 3'b011, 6'd1, 30'h10800});
    end

    // Zero-length request is ignored
    cap.delete();
    d0 = dones;
    u_req = 1'b1; u_req_wr = 1'b1; u_req_addr = 30'h40; u_req_len = '0;
    tick();
    u_req = 1'b0;
    repeat (10) @(negedge clk);
    chk("len0_rdy", 128'(u_req_rdy), 128'd1);
    chk("len0_no_done", 128'(dones), 128'(d0));
    chk("len0_no_cmd", 128'(cap.size()), 128'd0);
    tick();

    // Asynchronous reset in the middle of a read
    request(1'b0, 30'h3000, 200);
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rd_valid", 128'(u_rd_valid), 128'd0);
    chk("arst_rd_en", 128'(mcb_rd_en), 128'd0);
    chk("arst_cmd_en", 128'(mcb_cmd_en), 128'd0);
    chk("arst_done", 128'(u_done), 128'd0);
    repeat (3) @(posedge clk);
    #3;
    rd_fifo.delete();
    rd_pend = 0;
    exp_cmd.delete();
    rd_remaining = 0;
    exp_rd_next = rd_seq;
    mcb_rd_empty = 1'b1;
    mcb_rd_data = '0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_rdy_after", 128'(u_req_rdy), 128'd1);
    chk("arst_valid_after", 128'(u_rd_valid), 128'd0);
    tick();

    // Sticky error status
`ifdef MCB_ERR_LATCH_EN
    mcb_rd_overflow = 1'b1;
    tick();
    mcb_rd_overflow = 1'b0;
    @(negedge clk);
    chk("err_latched", 128'(err_status), 128'h4);
    repeat (5) @(negedge clk);
    chk("err_sticky", 128'(err_status), 128'h4);
    tick();
    request(1'b1, 30'h40, 1);
    @(negedge clk);
    chk("err_cleared", 128'(err_status), 128'h0);
    wait_done("err_wr", 100);
`else
    mcb_rd_overflow = 1'b1; mcb_rd_error = 1'b1; mcb_wr_error = 1'b1; mcb_wr_underrun = 1'b1;
    tick();
    mcb_rd_overflow = 1'b0; mcb_rd_error = 1'b0; mcb_wr_error = 1'b0; mcb_wr_underrun = 1'b0;
    @(negedge clk);
    chk("err_tied_zero", 128'(err_status), 128'h0);
    tick();
`endif

    repeat (5) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
